// File: rtl/lcd_pkg.sv
// Shared types, opcode masks and DDRAM address helpers for the HD44780-style LCD responder.
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_CLEAR = 2'd2
   } lcd_state_t;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_ENTRY     = 8'h04;
   localparam logic [7:0] CMD_DISP      = 8'h08;
   localparam logic [7:0] CMD_SHIFT     = 8'h10;
   localparam logic [7:0] CMD_FUNC      = 8'h20;
   localparam logic [7:0] CMD_CGRAM     = 8'h40;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

   localparam logic [6:0] LINE0_BASE = 7'h00;
   localparam logic [6:0] LINE1_BASE = 7'h40;
   localparam logic [7:0] SPACE_CHAR = 8'h20;

   function automatic logic [4:0] f_ddram_idx(input logic [6:0] addr);
      return {addr[6], addr[3:0]};
   endfunction

   // Column 15 / column 0 hop to the other line so the cursor walks both lines in a ring.
   function automatic logic [6:0] f_addr_step(input logic [6:0] addr, input logic inc);
      if (inc) begin
         if (addr[3:0] == 4'hF) return addr[6] ? LINE0_BASE : LINE1_BASE;
         else                   return addr + 7'd1;
      end else begin
         if (addr[3:0] == 4'h0) return addr[6] ? (LINE0_BASE | 7'h0F) : (LINE1_BASE | 7'h0F);
         else                   return addr - 7'd1;
      end
   endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Two-flop synchronizers for the LCD bus plus edge pulses on the synchronized enable.
module lcd_in_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rs,
   input  logic       i_rw,
   input  logic       i_en,
   input  logic [7:0] i_data,
   output logic       o_rs_s,
   output logic       o_rw_s,
   output logic       o_en_s,
   output logic [7:0] o_data_s,
   output logic       o_en_rise,
   output logic       o_en_fall
);

   logic       r_rs_m;
   logic       r_rw_m;
   logic       r_en_m;
   logic       r_en_d;
   logic [7:0] r_data_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rs_m   <= 1'b0;
         r_rw_m   <= 1'b0;
         r_en_m   <= 1'b0;
         r_data_m <= 8'h00;
         o_rs_s   <= 1'b0;
         o_rw_s   <= 1'b0;
         o_en_s   <= 1'b0;
         o_data_s <= 8'h00;
         r_en_d   <= 1'b0;
      end else begin
         r_rs_m   <= i_rs;
         r_rw_m   <= i_rw;
         r_en_m   <= i_en;
         r_data_m <= i_data;
         o_rs_s   <= r_rs_m;
         o_rw_s   <= r_rw_m;
         o_en_s   <= r_en_m;
         o_data_s <= r_data_m;
         r_en_d   <= o_en_s;
      end
   end

   assign o_en_rise = o_en_s & ~r_en_d;
   assign o_en_fall = ~o_en_s & r_en_d;

endmodule

// File: rtl/lcd_responder.sv
// Device side of a 2x16 HD44780-compatible LCD: instruction decode, DDRAM, busy timing, reads.
// Optional en-width / data-stability checker enabled by defining LCD_TIMING_CHECK_EN.
//
// state | meaning
// IDLE  | not busy, waiting for an accepted write
// EXEC  | busy, down-counting the instruction execution time
// CLEAR | busy, filling DDRAM with spaces one entry per cycle
module lcd_responder
   import lcd_pkg::*;
#(
   parameter int unsigned BUSY_CYCLES   = 2000,
   parameter int unsigned CLEAR_CYCLES  = 76500,
   parameter int unsigned MIN_EN_CYCLES = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs,
   input  logic       rw,
   input  logic       en,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       busy,
   output logic [6:0] addr_cnt,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   input  logic [4:0] dbg_idx,
   output logic [7:0] dbg_char,
   output logic       err_busy
`ifdef LCD_TIMING_CHECK_EN
   ,output logic      timing_err
`endif
);

   localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

   logic             w_rs_s, w_rw_s, w_en_s, w_en_rise, w_en_fall;
   logic [7:0]       w_data_s;

   lcd_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [4:0]       r_clr_idx, w_clr_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_pend;
   logic             r_cmd_rs;
   logic [7:0]       r_cmd_data;
   logic [6:0]       r_addr;
   logic             r_id;
   logic             r_disp, r_cursor, r_blink;
   logic [7:0]       r_mem [32];
   logic [7:0]       r_data_out;
   logic [7:0]       r_dbg;
   logic             r_err_busy;
   logic             w_busy_now, w_wr_fall, w_is_clear, w_is_home, w_clr_done;

   lcd_in_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rs      (rs),
      .i_rw      (rw),
      .i_en      (en),
      .i_data    (data_in),
      .o_rs_s    (w_rs_s),
      .o_rw_s    (w_rw_s),
      .o_en_s    (w_en_s),
      .o_data_s  (w_data_s),
      .o_en_rise (w_en_rise),
      .o_en_fall (w_en_fall)
   );

   assign w_busy_now = r_busy | r_pend;
   assign w_wr_fall  = w_en_fall & ~w_rw_s;
   assign w_is_clear = ~r_cmd_rs & (r_cmd_data == CMD_CLEAR);
   assign w_is_home  = ~r_cmd_rs & (r_cmd_data[7:2] == 6'd0) & r_cmd_data[1];
   assign w_clr_done = (r_state == ST_CLEAR) && (r_clr_idx == 5'd31);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_clr_idx <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_clr_idx <= w_clr_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_nxt   = r_clr_idx;
      w_busy_nxt  = r_busy;
      case (r_state)
         ST_IDLE: begin
            if (r_pend) begin
               w_busy_nxt = 1'b1;
               if (w_is_clear) begin
                  w_state_nxt = ST_CLEAR;
                  w_clr_nxt   = 5'd0;
               end else begin
                  w_state_nxt = ST_EXEC;
                  w_cnt_nxt   = w_is_home ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
               end
            end
         end
         ST_CLEAR: begin
            w_clr_nxt = r_clr_idx + 5'd1;
            if (r_clr_idx == 5'd31) begin
               // the 32 fill cycles count toward the clear execution time
               w_state_nxt = ST_EXEC;
               w_cnt_nxt   = CNT_W'(CLEAR_CYCLES - 33);
            end
         end
         ST_EXEC: begin
            if (r_cnt == '0) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend     <= 1'b0;
         r_cmd_rs   <= 1'b0;
         r_cmd_data <= 8'h00;
         r_err_busy <= 1'b0;
      end else begin
         r_pend <= w_wr_fall & ~w_busy_now;
         if (w_wr_fall & ~w_busy_now) begin
            r_cmd_rs   <= w_rs_s;
            r_cmd_data <= w_data_s;
         end
         if (w_wr_fall & w_busy_now) r_err_busy <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr   <= LINE0_BASE;
         r_id     <= 1'b1;
         r_disp   <= 1'b0;
         r_cursor <= 1'b0;
         r_blink  <= 1'b0;
      end else if (r_pend) begin
         if (r_cmd_rs)                               r_addr <= f_addr_step(r_addr, r_id);
         else if ((r_cmd_data & CMD_SET_DDRAM) != 0) r_addr <= r_cmd_data[6:0];
         else if ((r_cmd_data & (CMD_CGRAM | CMD_FUNC)) != 0) begin
         end
         else if ((r_cmd_data & CMD_SHIFT) != 0)     r_addr <= f_addr_step(r_addr, r_cmd_data[2]);
         else if ((r_cmd_data & CMD_DISP) != 0) begin
            r_disp   <= r_cmd_data[2];
            r_cursor <= r_cmd_data[1];
            r_blink  <= r_cmd_data[0];
         end
         else if ((r_cmd_data & CMD_ENTRY) != 0)     r_id   <= r_cmd_data[1];
         else if ((r_cmd_data & CMD_HOME) != 0)      r_addr <= LINE0_BASE;
      end else if (w_clr_done) begin
         r_addr <= LINE0_BASE;
         r_id   <= 1'b1;
      end else if (w_en_fall & w_rw_s & w_rs_s) begin
         r_addr <= f_addr_step(r_addr, r_id);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_mem[i] <= SPACE_CHAR;
      end else if (r_pend & r_cmd_rs) begin
         r_mem[f_ddram_idx(r_addr)] <= r_cmd_data;
      end else if (r_state == ST_CLEAR) begin
         r_mem[r_clr_idx] <= SPACE_CHAR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= 8'h00;
         r_dbg      <= SPACE_CHAR;
      end else begin
         if (w_en_rise & w_rw_s)
            r_data_out <= w_rs_s ? r_mem[f_ddram_idx(r_addr)] : {w_busy_now, r_addr};
         r_dbg <= r_mem[dbg_idx];
      end
   end

`ifdef LCD_TIMING_CHECK_EN
   localparam int EN_W = $clog2(MIN_EN_CYCLES + 1) + 1;
   localparam logic [EN_W-1:0] EN_MAX = '1;

   logic [EN_W-1:0] r_en_cnt;
   logic [7:0]      r_data_prev;
   logic            r_timing_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_cnt     <= '0;
         r_data_prev  <= 8'h00;
         r_timing_err <= 1'b0;
      end else begin
         r_data_prev <= w_data_s;
         if (w_en_rise)                          r_en_cnt <= EN_W'(1);
         else if (w_en_s && r_en_cnt != EN_MAX)  r_en_cnt <= r_en_cnt + 1'b1;
         if (w_en_fall && (r_en_cnt < EN_W'(MIN_EN_CYCLES)))
            r_timing_err <= 1'b1;
         if (w_en_s & ~w_en_rise & ~w_rw_s & (w_data_s != r_data_prev))
            r_timing_err <= 1'b1;
      end
   end

   assign timing_err = r_timing_err;
`else
   logic w_unused_min_en;
   assign w_unused_min_en = (MIN_EN_CYCLES > 0);
`endif

   assign data_out  = r_data_out;
   assign data_oe   = w_en_s & w_rw_s;
   assign busy      = r_busy;
   assign addr_cnt  = r_addr;
   assign disp_on   = r_disp;
   assign cursor_on = r_cursor;
   assign blink_on  = r_blink;
   assign dbg_char  = r_dbg;
   assign err_busy  = r_err_busy;

endmodule
